rd_serializer: RTL
==================

RD_SERIALIZER -- requirements
Module: rd_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8; bits per read word, legal range 2..32.
REQ-002 SHALL have parameter MSB_FIRST, default 1; 1 sends bit WIDTH-1 first, 0 sends bit 0 first.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ld_valid  input  1  parallel word offered for load.
REQ-006 SHALL have port ld_data  input  WIDTH  parallel read word.
REQ-007 SHALL have port ld_ready  output  1  block can accept a word this cycle.
REQ-008 SHALL have port flush  input  1  synchronous abort of the word in flight.
REQ-009 SHALL have port master_ready  input  1  downstream status-flag stage accepts the current bit.
REQ-010 SHALL have port rdata  output  1  current serial data bit.
REQ-011 SHALL have port valid  output  1  rdata holds a live bit.
REQ-012 SHALL have port done  output  1  one-cycle pulse after the last bit is accepted.
REQ-013 SHALL have port bit_cnt  output  $clog2(WIDTH+1)  bits still to send, including the current bit.

Function
REQ-014 SHALL use a 2-state FSM: IDLE and SEND.
REQ-015 In IDLE: ld_ready=1, valid=0, rdata=0.
REQ-016 IDLE->SEND when ld_valid=1 with ld_ready=1 at a clock edge; on that edge: ld_data captured into the shift register, bit_cnt loaded with WIDTH.
REQ-017 In SEND: ld_ready=0; ld_valid is ignored and ld_data is not sampled.
REQ-018 In SEND: valid=1 and rdata = first-order bit of the shift register, both registered, first bit visible the cycle after load.
REQ-019 Transfer rule: a bit is accepted on an edge where valid=1 and master_ready=1; only then does the shift register advance one position and bit_cnt decrement by 1.
REQ-020 Stall rule: while master_ready=0, rdata, valid and bit_cnt SHALL hold; no cap on stall length.
REQ-021 Last bit: acceptance with bit_cnt=1 -> next cycle IDLE, valid=0, bit_cnt=0, done=1 for exactly one cycle.
REQ-022 Latency: load edge to done pulse = WIDTH cycles minimum (master_ready held at 1), plus one cycle per stall cycle.
REQ-023 Back-to-back: one IDLE cycle (ld_ready=1) is required between words; valid deasserts for at least that cycle.
REQ-024 flush=1 in SEND: next cycle IDLE, valid=0, bit_cnt=0, shift register cleared, done SHALL NOT pulse; flush wins over a same-cycle acceptance.
REQ-025 flush=1 in IDLE: no effect on state; a same-cycle ld_valid is dropped (no load).
REQ-026 bit_cnt SHALL never wrap; it saturates at 0 in IDLE.
REQ-027 Shift-in fill bit SHALL be 0; rdata SHALL never show X after reset.

Reset
REQ-028 rst_n=0 SHALL immediately and asynchronously force IDLE, shift register=0, bit_cnt=0, rdata=0, valid=0, done=0, ld_ready=1.
REQ-029 Reset mid-word SHALL abandon the word without a done pulse; operation resumes on the first edge with rst_n=1.

Structure
REQ-030 A shared package SHALL hold the FSM state typedef (IDLE, SEND) and the default WIDTH constant.
REQ-031 One sub-module is natural: ser_shift_reg (parallel load, directional shift, hold enable); the FSM and counter SHALL stay in rd_serializer.

Verification
REQ-032 WIDTH=8, MSB_FIRST=1, ld_data=8'hA5, master_ready=1 -> rdata sequence 1,0,1,0,0,1,0,1 on 8 consecutive valid cycles; done pulses once, 8 cycles after load.
REQ-033 Same word, master_ready=0 for 3 cycles after bit 2 -> rdata/valid/bit_cnt (=6) frozen for 3 cycles; done 11 cycles after load.
REQ-034 MSB_FIRST=0, ld_data=8'h01 -> first rdata=1, then seven 0s; done pulses once.
REQ-035 flush asserted when bit_cnt=4 -> next cycle valid=0, bit_cnt=0, ld_ready=1, no done; next load 8'hFF sends eight 1s.
REQ-036 rst_n driven low between edges mid-word -> valid=0 and rdata=0 without waiting for a clock edge; no done; new load after release works.
REQ-037 ld_valid held high continuously with alternating words -> each word fully sent, exactly one IDLE cycle between words, no word skipped or duplicated.

Source files
------------

// File: rtl/rd_serializer_pkg.sv
// Shared definitions for the read-data serializer: FSM state encoding and
// the default word width.
package rd_serializer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Two-state FSM, kept as plain logic constants so legacy tools and
  // waveform viewers see a simple 1-bit encoding.
  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t SEND = 1'b1;

endpackage

// File: rtl/ser_shift_reg.sv
// Parallel-load shift register with directional shift, synchronous clear and
// hold. The fill bit is always 0, so after a full word has been shifted out
// the register is empty again.
module ser_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_data,
  output logic             first_bit
);

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_shifted;

  // Next value after one shift, in the configured direction, with 0 fill.
  generate
    if (MSB_FIRST) begin : g_msb
      assign sreg_shifted = {sreg[WIDTH-2:0], 1'b0};
      assign first_bit    = sreg[WIDTH-1];
    end else begin : g_lsb
      assign sreg_shifted = {1'b0, sreg[WIDTH-1:1]};
      assign first_bit    = sreg[0];
    end
  endgenerate

  // Register update: clear beats load, load beats shift, otherwise hold.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its neighbours; blocking here would create ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
    end else if (clear) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= load_data;
    end else if (shift) begin
      sreg <= sreg_shifted;
    end
  end

endmodule

// File: rtl/rd_serializer.sv
// Read-data serializer: accepts a parallel word when idle, then presents it
// one bit per accepted cycle under a valid/master_ready handshake. Signals
// the end of a word with a one-cycle done pulse; flush abandons the word.
module rd_serializer
  import rd_serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ld_valid,
  input  logic [WIDTH-1:0]           ld_data,
  output logic                       ld_ready,
  input  logic                       flush,
  input  logic                       master_ready,
  output logic                       rdata,
  output logic                       valid,
  output logic                       done,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

  localparam int CW = $clog2(WIDTH+1);

  state_t state;
  logic   first_bit;
  logic   load_fire;
  logic   accept;
  logic   last_accept;

  // A flush in IDLE drops a same-cycle load; in SEND it overrides acceptance.
  assign load_fire   = (state == IDLE) && ld_valid && !flush;
  assign accept      = (state == SEND) && master_ready;
  assign last_accept = accept && (bit_cnt == CW'(1));

  // Outputs decode straight from flops, so reset clears them without an edge.
  assign ld_ready = (state == IDLE);
  assign valid    = (state == SEND);
  assign rdata    = (state == SEND) && first_bit;

  ser_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_fire),
    .clear     (flush && (state == SEND)),
    .shift     (accept && !flush),
    .load_data (ld_data),
    .first_bit (first_bit)
  );

  // FSM, remaining-bit counter and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (load_fire) begin
          state   <= SEND;
          bit_cnt <= CW'(WIDTH);
        end
      end else begin
        if (flush) begin
          state   <= IDLE;
          bit_cnt <= '0;
        end else if (accept) begin
          bit_cnt <= bit_cnt - CW'(1);
          if (last_accept) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
      end
    end
  end

endmodule
